mdio_master_tx: RTL and testbench
=================================

MDIO_MASTER_TX -- requirements
Module: mdio_master_tx

Interface
REQ-001 No parameters; frame length fixed at 32 bits (ST 2, OP 2, PHYAD 5, REGAD 5, TA 2, DATA 16), no preamble generated.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 MDIO_START  input  1  request to start a frame; sampled only in IDLE.
REQ-005 T_DATA  input  32  frame to transmit; bit 31 is sent first; latched on accepted start.
REQ-006 MDIO_IN  input  1  serial data from the PHY, used during read data phase.
REQ-007 MDC  output  1  management clock, CLK/2 while a frame is active, 0 otherwise.
REQ-008 MDIO_OUT  output  1  serial data to the PHY.
REQ-009 MDIO_OE  output  1  1 = controller drives MDIO line.
REQ-010 MDIO_DONE  output  1  one-CLK pulse marking frame completion.
REQ-011 RD_DATA  output  16  data captured by the last completed read.

Function
REQ-012 States: IDLE, ACTIVE, DONE; IDLE->ACTIVE on edge with MDIO_START=1; ACTIVE->DONE after bit 31; DONE->IDLE unconditionally next edge.
REQ-013 Accept edge = E0; edges numbered E1, E2, ... thereafter; bit index k = 0..31.
REQ-014 At E0: latch T_DATA, k=0, MDC=0, MDIO_OE=1, MDIO_OUT=T_DATA[31].
REQ-015 MDC toggles every edge in ACTIVE: MDC=1 at E(2k+1), MDC=0 at E(2k+2).
REQ-016 At E(2k) for k=1..31: MDIO_OUT=T_DATA[31-k] (data changes on MDC falling edge, stable across rising edge).
REQ-017 Read frame = latched OP (bits 29:28) equal to 2'b10; any other OP (01, 00, 11) is a write frame, driven for all 32 bits.
REQ-018 Write frame: MDIO_OE=1 from E0 through E63; RD_DATA unchanged.
REQ-019 Read frame: MDIO_OE=1 for k=0..13 only; at E28 MDIO_OE=0 and MDIO_OUT=0, held until frame end.
REQ-020 Read frame: MDIO_IN sampled at E(2k+1) for k=16..31 (MDC rising edges), shifted MSB-first; TA bits (k=14,15) ignored.
REQ-021 At E64: state=DONE, MDC=0, MDIO_OE=0, MDIO_OUT=0, MDIO_DONE=1; if read frame, RD_DATA loaded with the 16 captured bits.
REQ-022 At E65: MDIO_DONE=0, state=IDLE; MDIO_DONE high exactly one CLK cycle per frame.
REQ-023 MDIO_START in ACTIVE or DONE ignored; T_DATA changes after E0 have no effect on the current frame.
REQ-024 MDIO_START held high continuously: next frame accepted at E66 (first edge seen in IDLE).
REQ-025 RD_DATA holds its value between reads, including across write frames.
REQ-026 In IDLE: MDC=0, MDIO_OE=0, MDIO_OUT=0, MDIO_DONE=0.

Reset
REQ-027 RESET=1 at an edge, any state: next state IDLE; MDC=0, MDIO_OE=0, MDIO_OUT=0, MDIO_DONE=0, RD_DATA=16'h0000, counters and shift registers cleared.
REQ-028 RESET mid-frame aborts without MDIO_DONE pulse and without updating RD_DATA; RESET has priority over MDIO_START.
REQ-029 First start accepted on the first edge with RESET=0 and MDIO_START=1.

Verification
REQ-030 Write: T_DATA=32'h5A5A1234 -> MDIO_OUT sequence 0101 1010 0101 1010 0001 0010 0011 0100 at E0,E2..E62, MDIO_OE=1 E0..E63, MDIO_DONE pulse at E64, RD_DATA unchanged.
REQ-031 Read: T_DATA=32'h6A200000, bench drives 16'h8FF1 MSB-first valid at E33..E63 -> MDIO_OE falls at E28, RD_DATA=16'h8FF1 and MDIO_DONE=1 after E64.
REQ-032 Busy start: pulse MDIO_START with different T_DATA at E10 -> ignored, first frame bit sequence intact, single MDIO_DONE.
REQ-033 Reset mid-frame: RESET=1 at E20 -> all outputs reset values next cycle, no MDIO_DONE, RD_DATA=0; subsequent read completes correctly.
REQ-034 Back-to-back: MDIO_START held high, two write frames -> second frame E0 lands 66 CLK after first, two MDIO_DONE pulses, MDC=0 in gap.
REQ-035 OP=2'b00 frame -> driven as write for full 32 bits, RD_DATA unchanged.

Source files
------------

// File: rtl/mdio_master_tx.sv
// MDIO management-frame transmitter: shifts out a 32-bit ST/OP/PHYAD/REGAD/TA/DATA
// frame on MDC = CLK/2 and, for read frames, captures 16 data bits from the PHY.
module mdio_master_tx (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mdio_start_i,
    input  logic [31:0] t_data_i,
    input  logic        mdio_in_i,
    output logic        mdc_o,
    output logic        mdio_out_o,
    output logic        mdio_oe_o,
    output logic        mdio_done_o,
    output logic [15:0] rd_data_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t      state_q;
    logic [5:0]  edge_q;
    logic [5:0]  edge_d;
    logic [30:0] frame_q;
    logic [15:0] shift_q;
    logic        rd_q;
    logic        mdc_q, out_q, oe_q, done_q;
    logic [15:0] rd_data_q;

    assign edge_d = edge_q + 6'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            frame_q   <= '0;
            shift_q   <= '0;
            rd_q      <= 1'b0;
            mdc_q     <= 1'b0;
            out_q     <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    mdc_q  <= 1'b0;
                    oe_q   <= 1'b0;
                    out_q  <= 1'b0;
                    if (mdio_start_i) begin
                        state_q <= ACTIVE;
                        edge_q  <= '0;
                        frame_q <= t_data_i[30:0];
                        rd_q    <= (t_data_i[29:28] == 2'b10);
                        oe_q    <= 1'b1;
                        out_q   <= t_data_i[31];
                    end
                end
                ACTIVE: begin
                    if (edge_q == 6'd63) begin
                        state_q <= DONE;
                        mdc_q   <= 1'b0;
                        oe_q    <= 1'b0;
                        out_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (rd_q)
                            rd_data_q <= shift_q;
                    end else begin
                        edge_q <= edge_d;
                        mdc_q  <= edge_d[0];
                        // Data advances on MDC falling edges so it is stable at the PHY's rising-edge sample.
                        if (!edge_d[0]) begin
                            out_q   <= frame_q[30];
                            frame_q <= {frame_q[29:0], 1'b0};
                        end
                        // Read frames release the line from the turnaround onward.
                        if (rd_q && edge_d >= 6'd28) begin
                            oe_q  <= 1'b0;
                            out_q <= 1'b0;
                        end
                        if (rd_q && edge_d[0] && edge_d >= 6'd33)
                            shift_q <= {shift_q[14:0], mdio_in_i};
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mdc_o       = mdc_q;
    assign mdio_out_o  = out_q;
    assign mdio_oe_o   = oe_q;
    assign mdio_done_o = done_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_mdio_master_tx.sv
// Directed bench for mdio_master_tx: per-edge expected outputs are queued as
// stimulus is driven and compared on the following falling CLK edge.
module tb_mdio_master_tx;

    logic        clk = 1'b0;
    logic        reset, start, mdio_in;
    logic [31:0] t_data;
    logic        mdc, mdio_out, mdio_oe, mdio_done;
    logic [15:0] rd_data;

    typedef struct packed {
        logic        mdc;
        logic        oe;
        logic        out;
        logic        done;
        logic [15:0] rd;
    } obs_t;

    obs_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] rd_model = 16'h0000;

    always #5 clk = ~clk;

    mdio_master_tx dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .mdio_start_i (start),
        .t_data_i     (t_data),
        .mdio_in_i    (mdio_in),
        .mdc_o        (mdc),
        .mdio_out_o   (mdio_out),
        .mdio_oe_o    (mdio_oe),
        .mdio_done_o  (mdio_done),
        .rd_data_o    (rd_data)
    );

    // Wait one edge, then compare the DUT against the oldest queued expectation.
    task automatic step_check(input string tag, input int j);
        obs_t got, exp;
        @(posedge clk);
        @(negedge clk);
        got = '{mdc, mdio_oe, mdio_out, mdio_done, rd_data};
        exp = sb.pop_front();
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s E%0d: got mdc/oe/out/done=%b%b%b%b rd=%h, want %b%b%b%b rd=%h",
                    tag, j, got.mdc, got.oe, got.out, got.done, got.rd,
                    exp.mdc, exp.oe, exp.out, exp.done, exp.rd);
    endtask

    task automatic idle_cycle(input string tag);
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, rd_model});
        step_check(tag, -1);
    endtask

    // Run one frame from the accept edge E0 through E65 (or until an injected reset).
    task automatic run_frame(input string tag, input logic [31:0] t, input logic [15:0] rdv,
                             input int busy_at, input int rst_at, input bit hold);
        bit   is_rd;
        obs_t e;
        is_rd  = (t[29:28] == 2'b10);
        start  = 1'b1;
        t_data = t;
        for (int j = 0; j <= 65; j++) begin
            if (j == rst_at) begin
                rd_model = 16'h0000;
                e = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
            end else if (j < 64) begin
                e.mdc  = j[0];
                e.oe   = is_rd ? (j < 28) : 1'b1;
                e.out  = (is_rd && j >= 28) ? 1'b0 : t[31 - j/2];
                e.done = 1'b0;
                e.rd   = rd_model;
            end else begin
                if (j == 64 && is_rd) rd_model = rdv;
                e = '{1'b0, 1'b0, 1'b0, (j == 64), rd_model};
            end
            sb.push_back(e);
            step_check(tag, j);
            if (j == rst_at) begin
                reset = 1'b0;
                start = 1'b0;
                break;
            end
            if (j == 0) t_data = ~t;
            start = hold || (j + 1 == busy_at);
            if (j + 1 == busy_at) t_data = 32'h5FFF0000;
            if (j + 1 == rst_at) reset = 1'b1;
            if (j >= 32 && j <= 62 && j[0] == 1'b0) mdio_in = rdv[15 - (j - 32)/2];
            else if (j == 63) mdio_in = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        t_data  = 32'h6A200000;
        mdio_in = 1'b0;
        @(negedge clk);
        // Reset beats a simultaneous start request.
        idle_cycle("reset");
        reset = 1'b0;
        start = 1'b0;
        idle_cycle("idle");

        run_frame("write", 32'h5A5A1234, 16'hFFFF, -1, -1, 1'b0);
        idle_cycle("idle_after_write");
        run_frame("read", 32'h6A200000, 16'h8FF1, -1, -1, 1'b0);
        run_frame("busy", 32'h5123ABCD, 16'h0000, 10, -1, 1'b0);
        idle_cycle("busy_ignored");
        run_frame("rst_mid", 32'h6A200000, 16'hA5A5, -1, 20, 1'b0);
        idle_cycle("after_rst");
        run_frame("read2", 32'h6A200000, 16'h3C5A, -1, -1, 1'b0);
        run_frame("b2b_1", 32'h5A5A1234, 16'h0000, -1, -1, 1'b1);
        run_frame("b2b_2", 32'h16A5C3E7, 16'h0000, -1, -1, 1'b0);
        run_frame("op00", 32'h0F0F8001, 16'hFFFF, -1, -1, 1'b0);
        idle_cycle("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
